// File: rtl/serial_out_pkg.sv
// Shared types and helpers for the multi-channel serial output engine.
package serial_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int unsigned DROP_CNT_W = 8;
  localparam int unsigned GAP_CNT_W  = 8;

  // Effective bits per frame: the requested count, limited to the word width.
  function automatic int unsigned clamp_len(input int unsigned count, input int unsigned limit);
    return (count > limit) ? limit : count;
  endfunction

endpackage

// File: rtl/serial_out_engine_if.sv
// Frame handshake bus between the frame resolver (master) and the serial output engine (slave).
interface serial_out_engine_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
);
  logic                     frame_valid;
  logic                     frame_ready;
  logic [NUM_CH*DATA_W-1:0] frame_data;
  logic [NUM_CH-1:0]        frame_vld_ch;
  logic [CNT_W-1:0]         frame_count;
  logic                     frame_crc_ok;

  modport master (
    output frame_valid, frame_data, frame_vld_ch, frame_count, frame_crc_ok,
    input  frame_ready
  );

  modport slave (
    input  frame_valid, frame_data, frame_vld_ch, frame_count, frame_crc_ok,
    output frame_ready
  );
endinterface

// File: rtl/gray2bin_dec.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_dec #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin_c
);

  logic acc;

  always_comb begin
    bin_c = '0;
    acc   = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      acc      = acc ^ gray[i];
      bin_c[i] = acc;
    end
  end

endmodule

// File: rtl/serial_out_engine.sv
// Accepts resolved frames, optionally Gray-decodes each channel word, and shifts N bits
// out on every enabled channel; bad frames are dropped and counted.
module serial_out_engine
  import serial_out_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CNT_W       = 16,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter bit          GRAY_DECODE = 1'b1,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                  clk_out16x,
  input  logic                  rst,
  serial_out_engine_if.slave    frm,
  output logic [NUM_CH-1:0]     data_out,
  output logic [NUM_CH-1:0]     data_vld,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_drop,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  state_t                 state;
  logic                   ready_q;
  logic [NUM_CH-1:0]      mask_q;
  logic [BIT_W-1:0]       bit_cnt;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic [DATA_W-1:0]      sreg [NUM_CH];

  int unsigned            n_c;
  logic                   accept_c;
  logic                   bad_c;
  logic [DATA_W-1:0]      dec_c       [NUM_CH];
  logic [DATA_W-1:0]      load_word_c [NUM_CH];
  logic [DATA_W-1:0]      load_rest_c [NUM_CH];
  logic [DATA_W-1:0]      run_rest_c  [NUM_CH];
  logic [NUM_CH-1:0]      load_bit_c;
  logic [NUM_CH-1:0]      run_bit_c;

  assign frm.frame_ready = ready_q;
  assign accept_c = frm.frame_valid && ready_q;
  assign bad_c    = !frm.frame_crc_ok || (frm.frame_vld_ch == '0) || (frm.frame_count == '0);

  // Per-channel word decode on the accept path.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    if (GRAY_DECODE) begin : g_dec
      gray2bin_dec #(.W(DATA_W)) u_dec (
        .gray  (frm.frame_data[c*DATA_W +: DATA_W]),
        .bin_c (dec_c[c])
      );
    end else begin : g_pass
      assign dec_c[c] = frm.frame_data[c*DATA_W +: DATA_W];
    end
  end

  // MSB-first pre-aligns bit N-1 to the top so both orders shift a fixed end out.
  always_comb begin
    n_c = clamp_len(32'(frm.frame_count), DATA_W);
    for (int c = 0; c < int'(NUM_CH); c++) begin
      load_word_c[c] = MSB_FIRST ? (dec_c[c] << (DATA_W - n_c)) : dec_c[c];
      load_bit_c[c]  = MSB_FIRST ? load_word_c[c][DATA_W-1] : load_word_c[c][0];
      load_rest_c[c] = MSB_FIRST ? (load_word_c[c] << 1) : (load_word_c[c] >> 1);
      run_bit_c[c]   = MSB_FIRST ? sreg[c][DATA_W-1] : sreg[c][0];
      run_rest_c[c]  = MSB_FIRST ? (sreg[c] << 1) : (sreg[c] >> 1);
    end
  end

  // FSM, counters, shift array and drop counter.
  always_ff @(posedge clk_out16x) begin
    if (rst) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b0;
      mask_q     <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      data_out   <= '0;
      data_vld   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      drop_cnt   <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) sreg[c] <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept_c) begin
            if (bad_c) begin
              frame_drop <= 1'b1;
              if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end else begin
              state    <= ST_SHIFT;
              busy     <= 1'b1;
              ready_q  <= 1'b0;
              mask_q   <= frm.frame_vld_ch;
              bit_cnt  <= BIT_W'(n_c - 1);
              data_out <= load_bit_c & frm.frame_vld_ch;
              data_vld <= frm.frame_vld_ch;
              for (int c = 0; c < int'(NUM_CH); c++) sreg[c] <= load_rest_c[c];
            end
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == '0) begin
            data_out   <= '0;
            data_vld   <= '0;
            frame_done <= 1'b1;
            if (GAP_CYCLES == 0) begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_CNT_W'(GAP_CYCLES - 1);
            end
          end else begin
            bit_cnt  <= bit_cnt - BIT_W'(1);
            data_out <= run_bit_c & mask_q;
            for (int c = 0; c < int'(NUM_CH); c++) sreg[c] <= run_rest_c[c];
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_out_engine.sv
// Bench for serial_out_engine: an 8-channel Gray/MSB-first/gap-2 instance and a
// 32-channel binary/LSB-first/gap-0 instance checked against a bit-sequence model.
module tb_serial_out_engine;
  import serial_out_pkg::*;

  localparam int NCH [2] = '{8, 32};
  localparam bit MSB [2] = '{1'b1, 1'b0};
  localparam bit GRY [2] = '{1'b1, 1'b0};
  localparam int GAP [2] = '{2, 0};

  logic clk;
  logic rst8, rst32;
  logic [7:0]  dout8, vld8;
  logic [31:0] dout32, vld32;
  logic        busy8, done8, drop8, busy32, done32, drop32;
  logic [7:0]  cnt8, cnt32;

  int vectors = 0;
  int miscompares = 0;
  int drops [2] = '{0, 0};

  serial_out_engine_if #(.NUM_CH(8),  .DATA_W(16), .CNT_W(16)) if8 ();
  serial_out_engine_if #(.NUM_CH(32), .DATA_W(16), .CNT_W(16)) if32 ();

  serial_out_engine #(.NUM_CH(8), .DATA_W(16), .CNT_W(16), .MSB_FIRST(1'b1),
                      .GRAY_DECODE(1'b1), .GAP_CYCLES(2)) dut8 (
    .clk_out16x(clk), .rst(rst8), .frm(if8.slave), .data_out(dout8), .data_vld(vld8),
    .busy(busy8), .frame_done(done8), .frame_drop(drop8), .drop_cnt(cnt8));

  serial_out_engine #(.NUM_CH(32), .DATA_W(16), .CNT_W(16), .MSB_FIRST(1'b0),
                      .GRAY_DECODE(1'b0), .GAP_CYCLES(0)) dut32 (
    .clk_out16x(clk), .rst(rst32), .frm(if32.slave), .data_out(dout32), .data_vld(vld32),
    .busy(busy32), .frame_done(done32), .frame_drop(drop32), .drop_cnt(cnt32));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: binary bit i of a Gray word is the XOR of all Gray bits at or above i.
  function automatic logic [15:0] g2b(input logic [15:0] g);
    logic [15:0] b;
    b = g;
    for (int s = 1; s < 16; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [31:0] exp_out(input int w, input logic [511:0] d,
                                          input logic [31:0] m, input int n, input int j);
    logic [31:0] v;
    logic [15:0] word, t;
    v = '0;
    for (int c = 0; c < NCH[w]; c++) begin
      word = d[c*16 +: 16];
      if (GRY[w]) word = g2b(word);
      t = MSB[w] ? (word >> (n - 1 - j)) : (word >> j);
      v[c] = t[0] & m[c];
    end
    return v;
  endfunction

  function automatic logic [31:0] get_out(input int w);  return (w == 0) ? 32'(dout8) : dout32; endfunction
  function automatic logic [31:0] get_vld(input int w);  return (w == 0) ? 32'(vld8)  : vld32;  endfunction
  function automatic logic [31:0] get_rdy(input int w);  return (w == 0) ? 32'(if8.frame_ready) : 32'(if32.frame_ready); endfunction
  function automatic logic [31:0] get_busy(input int w); return (w == 0) ? 32'(busy8) : 32'(busy32); endfunction
  function automatic logic [31:0] get_done(input int w); return (w == 0) ? 32'(done8) : 32'(done32); endfunction
  function automatic logic [31:0] get_drop(input int w); return (w == 0) ? 32'(drop8) : 32'(drop32); endfunction
  function automatic logic [31:0] get_cnt(input int w);  return (w == 0) ? 32'(cnt8)  : 32'(cnt32);  endfunction

  task automatic drive(input int w, input bit v, input logic [511:0] d, input logic [31:0] m,
                       input logic [15:0] cnt, input bit crc);
    if (w == 0) begin
      if8.frame_valid = v; if8.frame_data = d[127:0]; if8.frame_vld_ch = m[7:0];
      if8.frame_count = cnt; if8.frame_crc_ok = crc;
    end else begin
      if32.frame_valid = v; if32.frame_data = d; if32.frame_vld_ch = m;
      if32.frame_count = cnt; if32.frame_crc_ok = crc;
    end
  endtask

  task automatic set_valid(input int w, input bit v);
    if (w == 0) if8.frame_valid = v;
    else        if32.frame_valid = v;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic wait_ready(input int w);
    int t;
    t = 0;
    while (get_rdy(w) != 32'd1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", get_rdy(w), 32'd1);
  endtask

  function automatic void count_drop(input int w);
    if (drops[w] < 255) drops[w]++;
  endfunction

  // Offers one frame and checks every cycle until the engine is ready again.
  task automatic run_frame(input int w, input logic [511:0] d, input logic [31:0] m,
                           input int cnt, input bit crc);
    logic [31:0] mm;
    int n;
    mm = (NCH[w] == 32) ? m : (m & 32'hFF);
    n  = (cnt > 16) ? 16 : cnt;
    wait_ready(w);
    drive(w, 1'b1, d, m, 16'(cnt), crc);
    @(negedge clk);
    set_valid(w, 1'b0);
    if (!crc || mm == 0 || cnt == 0) begin
      count_drop(w);
      check("drop_pulse", get_drop(w), 32'd1);
      check("drop_cnt",   get_cnt(w),  32'(drops[w]));
      check("drop_vld",   get_vld(w),  32'd0);
      check("drop_ready", get_rdy(w),  32'd1);
      check("drop_busy",  get_busy(w), 32'd0);
      return;
    end
    for (int j = 0; j < n; j++) begin
      if (j > 0) @(negedge clk);
      check("shift_out",   get_out(w),  exp_out(w, d, mm, n, j));
      check("shift_vld",   get_vld(w),  mm);
      check("shift_done",  get_done(w), 32'd0);
      check("shift_ready", get_rdy(w),  32'd0);
      check("shift_busy",  get_busy(w), 32'd1);
      check("shift_drop",  get_drop(w), 32'd0);
    end
    @(negedge clk);
    check("done_pulse", get_done(w), 32'd1);
    check("done_vld",   get_vld(w),  32'd0);
    check("done_out",   get_out(w),  32'd0);
    for (int g = 0; g < GAP[w]; g++) begin
      check("gap_ready", get_rdy(w),  32'd0);
      check("gap_busy",  get_busy(w), 32'd1);
      check("gap_vld",   get_vld(w),  32'd0);
      @(negedge clk);
    end
    check("ready_back", get_rdy(w),  32'd1);
    check("idle_busy",  get_busy(w), 32'd0);
  endtask

  // Holds a CRC-failed frame valid for k consecutive accepts.
  task automatic burst_drops(input int w, input int k);
    wait_ready(w);
    drive(w, 1'b1, rand_data(), $urandom(), 16'($urandom_range(1, 16)), 1'b0);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      count_drop(w);
      check("burst_drop",  get_drop(w), 32'd1);
      check("burst_cnt",   get_cnt(w),  32'(drops[w]));
      check("burst_vld",   get_vld(w),  32'd0);
      check("burst_ready", get_rdy(w),  32'd1);
      if (i == k - 1) set_valid(w, 1'b0);
    end
    @(negedge clk);
    check("burst_end_drop", get_drop(w), 32'd0);
    check("burst_end_cnt",  get_cnt(w),  32'(drops[w]));
  endtask

  initial begin
    logic [511:0] d;
    logic [31:0]  m;

    rst8 = 1'b1;
    rst32 = 1'b1;
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check("rst_ready", get_rdy(w),  32'd0);
      check("rst_out",   get_out(w),  32'd0);
      check("rst_vld",   get_vld(w),  32'd0);
      check("rst_busy",  get_busy(w), 32'd0);
      check("rst_done",  get_done(w), 32'd0);
      check("rst_drop",  get_drop(w), 32'd0);
      check("rst_cnt",   get_cnt(w),  32'd0);
    end
    rst8 = 1'b0;
    rst32 = 1'b0;
    @(negedge clk);
    check("ready_after_rst8",  get_rdy(0), 32'd1);
    check("ready_after_rst32", get_rdy(1), 32'd1);

    // ch0 Gray 0x8000 decodes to all ones; other channels masked off
    d = rand_data();
    d[15:0] = 16'h8000;
    run_frame(0, d, 32'h01, 16, 1'b1);

    // binary 0xA5 on ch7, LSB first, 8 bits
    d = rand_data();
    d[7*16 +: 16] = 16'h00A5;
    run_frame(1, d, 32'h80, 8, 1'b1);

    burst_drops(0, 3);
    check("three_drops", get_cnt(0), 32'd3);

    run_frame(0, rand_data(), 32'hA5, 40, 1'b1);
    run_frame(0, rand_data(), 32'h00, 12, 1'b1);
    run_frame(0, rand_data(), 32'hFF, 0,  1'b1);
    run_frame(1, rand_data(), 32'hFFFF_FFFF, 1, 1'b1);
    run_frame(1, rand_data(), 32'hFFFF_FFFF, 16, 1'b1);

    for (int i = 0; i < 24; i++) begin
      for (int w = 0; w < 2; w++) begin
        m = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom();
        run_frame(w, rand_data(), m, int'($urandom_range(0, 40)), $urandom_range(0, 7) != 0);
      end
    end

    burst_drops(1, 260);
    check("drop_sat", get_cnt(1), 32'd255);
    run_frame(1, rand_data(), 32'h0F0F_F0F0, 5, 1'b0);
    check("drop_sat_hold", get_cnt(1), 32'd255);

    // reset while bit 5 of a 16-bit frame is on the wire
    wait_ready(0);
    drive(0, 1'b1, rand_data(), 32'hFF, 16'd16, 1'b1);
    @(negedge clk);
    set_valid(0, 1'b0);
    repeat (5) @(negedge clk);
    check("midframe_vld", get_vld(0), 32'hFF);
    rst8 = 1'b1;
    @(negedge clk);
    drops[0] = 0;
    check("abort_out",   get_out(0),  32'd0);
    check("abort_vld",   get_vld(0),  32'd0);
    check("abort_busy",  get_busy(0), 32'd0);
    check("abort_done",  get_done(0), 32'd0);
    check("abort_ready", get_rdy(0),  32'd0);
    check("abort_cnt",   get_cnt(0),  32'd0);
    rst8 = 1'b0;
    @(negedge clk);
    check("abort_ready_back", get_rdy(0),  32'd1);
    check("abort_no_done",    get_done(0), 32'd0);
    run_frame(0, rand_data(), $urandom() | 32'h1, 16, 1'b1);
    run_frame(0, rand_data(), $urandom() | 32'h1, 7,  1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
